// File: rtl/modulator_pkg.sv
// Shared types and helpers for the modulator transmit sequencer.
// Mode encodings, FSM state encoding and bit-period selection.
package modulator_pkg;

  localparam logic [1:0] MOD_FSK  = 2'b00;
  localparam logic [1:0] MOD_ASK  = 2'b01;
  localparam logic [1:0] MOD_BPSK = 2'b10;
  localparam logic [1:0] MOD_QPSK = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StShift,
    StGap
  } state_e;

  function automatic logic [9:0] bit_period(input logic [1:0] mod,
                                            input logic [9:0] sym_clks,
                                            input logic [9:0] qpsk_clks);
    return (mod == MOD_QPSK) ? qpsk_clks : sym_clks;
  endfunction

endpackage

// File: rtl/modulator_tx_sequencer_if.sv
// Byte stream valid/ready channel from the packet source into the sequencer.
interface modulator_tx_sequencer_if;

  logic [7:0] byte_data;
  logic       byte_valid;
  logic       byte_ready;

  modport master (output byte_data, output byte_valid, input byte_ready);
  modport slave  (input byte_data, input byte_valid, output byte_ready);

endinterface

// File: rtl/bit_period_timer.sv
// Loadable down-counter; tc_o is high while the count sits at zero.
module bit_period_timer #(
  parameter int unsigned Width = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  output logic             tc_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/modulator_tx_sequencer.sv
// Frame sequencer: takes bytes over valid/ready, shifts them out MSB-first on din,
// holding each bit for the mode's bit period, then idles for a gap and pulses done.
module modulator_tx_sequencer
  import modulator_pkg::*;
#(
  parameter int unsigned SYMBOL_CLKS   = 512,
  parameter int unsigned QPSK_BIT_CLKS = 64,
  parameter int unsigned GAP_CLKS      = 64
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [1:0]                      cfg_mod,
  input  logic [1:0]                      cfg_freq,
  input  logic [7:0]                      frame_len,
  modulator_tx_sequencer_if.slave         byte_if,
  output logic                            din,
  output logic [1:0]                      mod,
  output logic [1:0]                      freq,
  output logic                            qpsk_pulse,
  output logic                            busy,
  output logic                            done,
  output logic                            underrun
);

  localparam logic [9:0] SymClks  = 10'(SYMBOL_CLKS);
  localparam logic [9:0] QpskClks = 10'(QPSK_BIT_CLKS);
  localparam logic [9:0] GapM1    = 10'(GAP_CLKS - 1);

  state_e     state_q, state_d;
  logic [1:0] mod_q, mod_d, freq_q, freq_d;
  logic [7:0] len_q, len_d;
  logic [7:0] hold_q, hold_d, shift_q, shift_d;
  logic       hold_full_q, hold_full_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic [7:0] req_cnt_q, req_cnt_d, ld_cnt_q, ld_cnt_d;
  logic       qpsk_q, qpsk_d, done_q, done_d, underrun_q, underrun_d;

  logic       byte_ready, byte_xfer;
  logic       tmr_load, tmr_tc;
  logic [9:0] tmr_val, period_m1;

  assign busy       = (state_q != StIdle);
  assign byte_ready = busy && !hold_full_q && (req_cnt_q < len_q);
  assign byte_xfer  = byte_if.byte_valid && byte_ready;
  assign period_m1  = bit_period(mod_q, SymClks, QpskClks) - 10'd1;

  bit_period_timer #(
    .Width (10)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .tc_o       (tmr_tc)
  );

  always_comb begin
    state_d     = state_q;
    mod_d       = mod_q;
    freq_d      = freq_q;
    len_d       = len_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    bit_idx_d   = bit_idx_q;
    req_cnt_d   = req_cnt_q;
    ld_cnt_d    = ld_cnt_q;
    qpsk_d      = qpsk_q;
    underrun_d  = underrun_q;
    done_d      = 1'b0;
    tmr_load    = 1'b0;
    tmr_val     = period_m1;

    if (byte_xfer) begin
      hold_d      = byte_if.byte_data;
      hold_full_d = 1'b1;
      req_cnt_d   = req_cnt_q + 8'd1;
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (frame_len == 8'd0) begin
            done_d = 1'b1;
          end else begin
            mod_d       = cfg_mod;
            freq_d      = cfg_freq;
            len_d       = frame_len;
            underrun_d  = 1'b0;
            req_cnt_d   = 8'd0;
            ld_cnt_d    = 8'd0;
            hold_full_d = 1'b0;
            qpsk_d      = 1'b0;
            state_d     = StLoad;
          end
        end
      end
      StLoad: begin
        if (hold_full_q) begin
          shift_d     = hold_q;
          hold_full_d = 1'b0;
          ld_cnt_d    = ld_cnt_q + 8'd1;
          bit_idx_d   = 3'd0;
          tmr_load    = 1'b1;
          state_d     = StShift;
        end
      end
      StShift: begin
        if (tmr_tc) begin
          shift_d   = {shift_q[6:0], 1'b0};
          bit_idx_d = bit_idx_q + 3'd1;
          tmr_load  = 1'b1;
          if (mod_q == MOD_QPSK) begin
            qpsk_d = ~qpsk_q;
          end
          if (bit_idx_q == 3'd7) begin
            if (ld_cnt_q == len_q) begin
              state_d = StGap;
              qpsk_d  = 1'b0;
              tmr_val = GapM1;
            end else if (hold_full_q) begin
              // Back-to-back byte: no idle slot between bytes.
              shift_d     = hold_q;
              hold_full_d = 1'b0;
              ld_cnt_d    = ld_cnt_q + 8'd1;
            end else begin
              underrun_d = 1'b1;
              tmr_load   = 1'b0;
              state_d    = StLoad;
            end
          end
        end
      end
      StGap: begin
        if (tmr_tc) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      mod_q       <= 2'b00;
      freq_q      <= 2'b00;
      len_q       <= 8'd0;
      hold_q      <= 8'd0;
      hold_full_q <= 1'b0;
      shift_q     <= 8'd0;
      bit_idx_q   <= 3'd0;
      req_cnt_q   <= 8'd0;
      ld_cnt_q    <= 8'd0;
      qpsk_q      <= 1'b0;
      done_q      <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      mod_q       <= mod_d;
      freq_q      <= freq_d;
      len_q       <= len_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      bit_idx_q   <= bit_idx_d;
      req_cnt_q   <= req_cnt_d;
      ld_cnt_q    <= ld_cnt_d;
      qpsk_q      <= qpsk_d;
      done_q      <= done_d;
      underrun_q  <= underrun_d;
    end
  end

  assign byte_if.byte_ready = byte_ready;
  assign din        = (state_q == StShift) ? shift_q[7] : 1'b0;
  assign mod        = mod_q;
  assign freq       = freq_q;
  assign qpsk_pulse = qpsk_q;
  assign done       = done_q;
  assign underrun   = underrun_q;

endmodule

// File: tb/tb_modulator_tx_sequencer.sv
// Scoreboard bench: each test pushes the expected per-cycle din/qpsk/mod/freq waveform of
// a frame; a monitor pops one entry per busy cycle and one done entry per done pulse.
module tb_modulator_tx_sequencer;

  localparam int SC = 512;
  localparam int QB = 64;
  localparam int GP = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [1:0] cfg_mod = 2'b00;
  logic [1:0] cfg_freq = 2'b00;
  logic [7:0] frame_len = 8'd0;
  logic       din, qpsk_pulse, busy, done, underrun;
  logic [1:0] mod, freq;

  modulator_tx_sequencer_if byte_bus ();

  modulator_tx_sequencer #(
    .SYMBOL_CLKS   (SC),
    .QPSK_BIT_CLKS (QB),
    .GAP_CLKS      (GP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .cfg_mod    (cfg_mod),
    .cfg_freq   (cfg_freq),
    .frame_len  (frame_len),
    .byte_if    (byte_bus.slave),
    .din        (din),
    .mod        (mod),
    .freq       (freq),
    .qpsk_pulse (qpsk_pulse),
    .busy       (busy),
    .done       (done),
    .underrun   (underrun)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       din;
    logic       qpsk;
    logic [1:0] mod;
    logic [1:0] freq;
  } obs_t;

  obs_t exp_q[$];
  int   done_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic void chk(input string name, input int act, input int expv);
    n_vec++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
    end
  endfunction

  // Expected frame: 2 LOAD cycles, 8 bits per byte of p clocks each, optional idle
  // slot before byte 1 (underrun), then the gap; qpsk toggles at each bit boundary.
  task automatic push_frame(input logic [1:0] m, input logic [1:0] f, input logic [7:0] b0,
                            input logic [7:0] b1, input int n, input int gap1);
    int p;
    int k;
    logic [7:0] bv;
    p = (m == 2'b11) ? QB : SC;
    k = 0;
    repeat (2) exp_q.push_back({1'b0, 1'b0, m, f});
    for (int i = 0; i < n; i++) begin
      bv = (i == 0) ? b0 : b1;
      if (i == 1) repeat (gap1) exp_q.push_back({1'b0, 1'b0, m, f});
      for (int j = 7; j >= 0; j--) begin
        repeat (p) exp_q.push_back({bv[j], (m == 2'b11) ? k[0] : 1'b0, m, f});
        k++;
      end
    end
    repeat (GP) exp_q.push_back({1'b0, 1'b0, m, f});
    done_q.push_back(1);
  endtask

  // Monitor: one expected entry per busy cycle, one done entry per done pulse.
  initial begin
    obs_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (busy) begin
          if (exp_q.size() == 0) begin
            chk("busy_beyond_frame", int'(busy), 0);
          end else begin
            e = exp_q.pop_front();
            chk("wave{din,qpsk,mod,freq}", int'({din, qpsk_pulse, mod, freq}), int'(e));
          end
        end
        if (done) begin
          if (done_q.size() == 0) begin
            chk("done_unexpected", int'(done), 0);
          end else begin
            void'(done_q.pop_front());
            chk("done_busy_low", int'(busy), 0);
            chk("frame_cycles_left", exp_q.size(), 0);
          end
        end
      end
    end
  end

  task automatic send_wait(input logic [7:0] d);
    bit got;
    got = 1'b0;
    byte_bus.byte_data  = d;
    byte_bus.byte_valid = 1'b1;
    for (int i = 0; i < 20000 && !got; i++) begin
      @(negedge clk);
      got = byte_bus.byte_ready;
      @(posedge clk);
      #1;
    end
    byte_bus.byte_valid = 1'b0;
    if (!got) chk("accept_timeout", int'(byte_bus.byte_ready), 1);
  endtask

  task automatic start_frame(input logic [1:0] m, input logic [1:0] f, input logic [7:0] len,
                             input logic [7:0] b0);
    cfg_mod   = m;
    cfg_freq  = f;
    frame_len = len;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    send_wait(b0);
  endtask

  task automatic wait_done(input int limit, output int hits);
    bit seen;
    seen = 1'b0;
    hits = 0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      if (byte_bus.byte_valid && byte_bus.byte_ready) hits++;
      seen = done;
    end
    if (!seen) chk("done_timeout", int'(done), 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int hits;
    byte_bus.byte_data  = 8'h00;
    byte_bus.byte_valid = 1'b0;
    #12;
    chk("rst_din", int'(din), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_ready", int'(byte_bus.byte_ready), 0);
    chk("rst_mod_freq", int'({mod, freq}), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 1: BPSK, one byte A5.
    push_frame(2'b10, 2'b01, 8'hA5, 8'h00, 1, 0);
    start_frame(2'b10, 2'b01, 8'd1, 8'hA5);
    wait_done(20000, hits);
    chk("t1_underrun", int'(underrun), 0);

    // 2: QPSK, two bytes back-to-back.
    push_frame(2'b11, 2'b10, 8'hC3, 8'h5A, 2, 0);
    start_frame(2'b11, 2'b10, 8'd2, 8'hC3);
    send_wait(8'h5A);
    wait_done(20000, hits);
    chk("t2_underrun", int'(underrun), 0);
    chk("t2_qpsk_idle", int'(qpsk_pulse), 0);

    // 3: FSK, second byte late -> 100 idle clocks and sticky underrun.
    push_frame(2'b00, 2'b11, 8'h81, 8'h7E, 2, 100);
    start_frame(2'b00, 2'b11, 8'd2, 8'h81);
    repeat (8 * SC + 99) @(posedge clk);
    #1;
    send_wait(8'h7E);
    wait_done(20000, hits);
    chk("t3_underrun", int'(underrun), 1);

    // 4: zero-length frame: done next cycle, no busy, no byte taken, mod unchanged.
    done_q.push_back(1);
    cfg_mod             = 2'b11;
    cfg_freq            = 2'b00;
    frame_len           = 8'd0;
    byte_bus.byte_valid = 1'b1;
    byte_bus.byte_data  = 8'hEE;
    start               = 1'b1;
    @(negedge clk);
    chk("t4_ready_s", int'(byte_bus.byte_ready), 0);
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    chk("t4_done", int'(done), 1);
    chk("t4_ready", int'(byte_bus.byte_ready), 0);
    chk("t4_mod_freq", int'({mod, freq}), int'({2'b00, 2'b11}));
    @(negedge clk);
    chk("t4_done_width", int'(done), 0);
    byte_bus.byte_valid = 1'b0;
    @(posedge clk);
    #1;

    // 5: reset mid-bit with a second byte waiting in the hold register.
    push_frame(2'b00, 2'b01, 8'hF0, 8'h0F, 2, 0);
    start_frame(2'b00, 2'b01, 8'd2, 8'hF0);
    send_wait(8'h0F);
    repeat (300) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_din", int'(din), 0);
    chk("t5_busy", int'(busy), 0);
    chk("t5_freq", int'(freq), 0);
    chk("t5_ready", int'(byte_bus.byte_ready), 0);
    chk("t5_qpsk_done_urun", int'({qpsk_pulse, done, underrun}), 0);
    exp_q.delete();
    done_q.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    push_frame(2'b01, 2'b10, 8'h3C, 8'h00, 1, 0);
    start_frame(2'b01, 2'b10, 8'd1, 8'h3C);
    wait_done(20000, hits);

    // 6: start/cfg changes while busy are ignored; surplus byte is never accepted.
    push_frame(2'b10, 2'b11, 8'h96, 8'h00, 1, 0);
    start_frame(2'b10, 2'b11, 8'd1, 8'h96);
    byte_bus.byte_data  = 8'h77;
    byte_bus.byte_valid = 1'b1;
    repeat (1000) @(posedge clk);
    #1;
    cfg_mod   = 2'b11;
    cfg_freq  = 2'b00;
    frame_len = 8'd5;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(20000, hits);
    chk("t6_ready_after_len", hits, 0);
    byte_bus.byte_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("t6_no_restart", int'(busy), 0);
    chk("t6_pending", exp_q.size() + done_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
